// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: 640x480@60 raster generator and framebuffer read side.
// Issues one framebuffer read per active pixel and returns the grey sample
// as r/g/b with sync, blank and DE delayed so every output describes the
// same pixel. Total latency from counter state to outputs is RD_LATENCY+2.
module vga_fb_scanout #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned ADDR_W     = 19
) (
    input  logic              pclk,
    input  logic              reset_n,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              hs,
    output logic              vs,
    output logic              VGA_HB,
    output logic              VGA_VB,
    output logic              VGA_DE,
    output logic              vblank_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned LAT     = RD_LATENCY + 2;
    // One spare bit so the sync end bound fits even when the back porch is 0.
    localparam int unsigned HW      = $clog2(H_TOTAL + 1);
    localparam int unsigned VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_ACT_C    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    // Per-pixel attributes carried down the delay line.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic hblank;
        logic vblank;
        logic vbs;      // first pixel of line V_ACTIVE
    } pix_t;

    localparam pix_t PIX_BLANK = '{active: 1'b0, hsync: 1'b0, vsync: 1'b0,
                                   hblank: 1'b1, vblank: 1'b1, vbs: 1'b0};

    logic [HW-1:0]     h_q;
    logic [VW-1:0]     v_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              h_last;
    logic              v_last;
    pix_t              pix0;
    pix_t [LAT-1:0]    pipe_q;
    pix_t              pix_o;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [7:0]        grey_q;

    // Stage 0 decode of the raster position.
    always_comb begin
        h_last      = (h_q == H_LAST);
        v_last      = (v_q == V_LAST);
        pix0.active = (h_q < H_ACT_C) && (v_q < V_ACT_C);
        pix0.hsync  = (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END);
        pix0.vsync  = (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END);
        pix0.hblank = (h_q >= H_ACT_C);
        pix0.vblank = (v_q >= V_ACT_C);
        pix0.vbs    = (h_q == '0) && (v_q == V_ACT_C);
    end

    // Horizontal and vertical raster counters; both wrap together at frame end.
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_last) begin
            h_q <= '0;
            v_q <= v_last ? '0 : v_q + VW'(1);
        end else begin
            h_q <= h_q + HW'(1);
        end
    end

    // Linear address follows active pixels only, so no y*H_ACTIVE multiply is needed.
    // It saturates on the last active pixel and restarts in the last frame cycle.
    always_comb begin
        addr_d = addr_q;
        if (h_last && v_last) begin
            addr_d = '0;
        end else if (pix0.active && (addr_q != ADDR_MAX)) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    // Address counter register.
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Registered framebuffer read port for the stage 0 pixel.
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rd_en_q   <= pix0.active;
            rd_addr_q <= addr_q;
        end
    end

    // Attribute delay line matching the read path latency.
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            pipe_q <= {LAT{PIX_BLANK}};
        end else begin
            pipe_q <= {pipe_q[LAT-2:0], pix0};
        end
    end

    // Capture the returned sample; forced to black so blanking never shows rd_data.
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            grey_q <= 8'h00;
        end else begin
            grey_q <= pipe_q[LAT-2].active ? rd_data : 8'h00;
        end
    end

    // Output drive from the last delay stage.
    always_comb begin
        pix_o        = pipe_q[LAT-1];
        rd_en        = rd_en_q;
        rd_addr      = rd_addr_q;
        r            = grey_q;
        g            = grey_q;
        b            = grey_q;
        hs           = pix_o.hsync ? HS_POL : ~HS_POL;
        vs           = pix_o.vsync ? VS_POL : ~VS_POL;
        VGA_HB       = pix_o.hblank;
        VGA_VB       = pix_o.vblank;
        // active is exactly ~(hblank | vblank) by construction of stage 0.
        VGA_DE       = pix_o.active;
        vblank_start = pix_o.vbs;
    end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Testbench for vga_fb_scanout: one full-size instance and two reduced-timing
// instances (RD_LATENCY 1 and 3) compared every cycle against a reference model
// that derives the expected raster position from the cycles elapsed since reset.
module tb_vga_fb_scanout;

    logic        clk = 1'b0;
    logic        reset_n;
    int          mode;
    logic [31:0] key;
    int          k;
    int          total;
    int          bad;
    int          first_de_k;
    bit          win;
    int          cnt_hs;
    int          cnt_de;
    int          aa_bad;
    int          prev [2];
    bit          pv [2];
    int          cvs [2];
    int          cvb [2];
    int          target;

    always #5 clk = ~clk;

    // Full-size instance signals.
    logic        u0_rd_en, u0_hs, u0_vs, u0_hb, u0_vb, u0_de, u0_vbs;
    logic [18:0] u0_rd_addr;
    logic [7:0]  u0_rd_data, u0_r, u0_g, u0_b;
    // Reduced-timing instance, RD_LATENCY = 1.
    logic        u1_rd_en, u1_hs, u1_vs, u1_hb, u1_vb, u1_de, u1_vbs;
    logic [9:0]  u1_rd_addr;
    logic [7:0]  u1_rd_data, u1_r, u1_g, u1_b;
    // Reduced-timing instance, RD_LATENCY = 3, active-high hsync.
    logic        u3_rd_en, u3_hs, u3_vs, u3_hb, u3_vb, u3_de, u3_vbs;
    logic [9:0]  u3_rd_addr;
    logic [7:0]  u3_rd_data, u3_r, u3_g, u3_b;

    vga_fb_scanout u0 (
        .pclk(clk), .reset_n(reset_n), .rd_en(u0_rd_en), .rd_addr(u0_rd_addr),
        .rd_data(u0_rd_data), .r(u0_r), .g(u0_g), .b(u0_b), .hs(u0_hs), .vs(u0_vs),
        .VGA_HB(u0_hb), .VGA_VB(u0_vb), .VGA_DE(u0_de), .vblank_start(u0_vbs)
    );

    vga_fb_scanout #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b0), .VS_POL(1'b0), .RD_LATENCY(1), .ADDR_W(10)
    ) u1 (
        .pclk(clk), .reset_n(reset_n), .rd_en(u1_rd_en), .rd_addr(u1_rd_addr),
        .rd_data(u1_rd_data), .r(u1_r), .g(u1_g), .b(u1_b), .hs(u1_hs), .vs(u1_vs),
        .VGA_HB(u1_hb), .VGA_VB(u1_vb), .VGA_DE(u1_de), .vblank_start(u1_vbs)
    );

    vga_fb_scanout #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b1), .VS_POL(1'b0), .RD_LATENCY(3), .ADDR_W(10)
    ) u3 (
        .pclk(clk), .reset_n(reset_n), .rd_en(u3_rd_en), .rd_addr(u3_rd_addr),
        .rd_data(u3_rd_data), .r(u3_r), .g(u3_g), .b(u3_b), .hs(u3_hs), .vs(u3_vs),
        .VGA_HB(u3_hb), .VGA_VB(u3_vb), .VGA_DE(u3_de), .vblank_start(u3_vbs)
    );

    // Framebuffer contents as a function of address and the current mode.
    function automatic logic [7:0] fbval(input int m, input logic [31:0] kk,
                                         input logic [19:0] a);
        logic [31:0] t;
        t = 32'(a) * kk;
        case (m)
            0:       return 8'hFF;
            1:       return a[7:0];
            2:       return 8'hAA;
            default: return t[12:5];
        endcase
    endfunction

    // Framebuffer models with 1 and 3 cycles of read latency.
    logic [19:0] a0_q, a1_q, a3_q1, a3_q2, a3_q3;
    always @(posedge clk) begin
        a0_q  <= 20'(u0_rd_addr);
        a1_q  <= 20'(u1_rd_addr);
        a3_q1 <= 20'(u3_rd_addr);
        a3_q2 <= a3_q1;
        a3_q3 <= a3_q2;
    end
    assign u0_rd_data = fbval(mode, key, a0_q);
    assign u1_rd_data = fbval(mode, key, a1_q);
    assign u3_rd_data = fbval(mode, key, a3_q3);

    logic [50:0] obs0, obs1, obs3;
    assign obs0 = {u0_rd_en, 20'(u0_rd_addr), u0_r, u0_g, u0_b,
                   u0_hs, u0_vs, u0_hb, u0_vb, u0_de, u0_vbs};
    assign obs1 = {u1_rd_en, 20'(u1_rd_addr), u1_r, u1_g, u1_b,
                   u1_hs, u1_vs, u1_hb, u1_vb, u1_de, u1_vbs};
    assign obs3 = {u3_rd_en, 20'(u3_rd_addr), u3_r, u3_g, u3_b,
                   u3_hs, u3_vs, u3_hb, u3_vb, u3_de, u3_vbs};

    // Reference: k cycles after the last reset edge, the read port shows pixel
    // k-1 and the video outputs show pixel k-L, pixels numbered in raster order.
    task automatic chk(input string tag, input logic [50:0] obs,
                       input int ha, input int hfp, input int hsw, input int hbp,
                       input int va, input int vfp, input int vsw, input int vbp,
                       input int lat, input bit hp, input bit vp, input int m);
        int ht, vt, fr, p, h, v, lt;
        logic ren, hs_e, vs_e, hb_e, vb_e, de_e, vbs_e;
        logic [19:0] ea;
        logic [7:0]  px;
        logic [50:0] ev, em;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        fr = ht * vt;
        lt = lat + 2;
        em = '1;
        if (k == 0) begin
            ren = 1'b0;
            ea  = '0;
        end else begin
            p   = (k - 1) % fr;
            h   = p % ht;
            v   = p / ht;
            ren = (h < ha) && (v < va);
            ea  = 20'(v * ha + h);
            if (!ren) em[49:30] = '0;
        end
        if (k < lt) begin
            px = 8'h00; hs_e = ~hp; vs_e = ~vp; hb_e = 1'b1; vb_e = 1'b1;
            de_e = 1'b0; vbs_e = 1'b0;
        end else begin
            p     = (k - lt) % fr;
            h     = p % ht;
            v     = p / ht;
            hb_e  = (h >= ha);
            vb_e  = (v >= va);
            de_e  = !hb_e && !vb_e;
            hs_e  = (h >= ha + hfp && h < ha + hfp + hsw) ? hp : ~hp;
            vs_e  = (v >= va + vfp && v < va + vfp + vsw) ? vp : ~vp;
            vbs_e = (h == 0) && (v == va);
            px    = de_e ? fbval(m, key, 20'(v * ha + h)) : 8'h00;
        end
        ev = {ren, ea, px, px, px, hs_e, vs_e, hb_e, vb_e, de_e, vbs_e};
        total++;
        assert ((obs & em) === (ev & em)) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs & em, ev & em);
        end
    endtask

    // Frame-level totals on the reduced instances, checked at each vblank_start.
    task automatic frame_chk(input int idx, input logic vbs, input logic vsv, input logic vbv);
        if (k == 0) begin
            pv[idx] = 1'b0; cvs[idx] = 0; cvb[idx] = 0;
            return;
        end
        if (vbs) begin
            if (pv[idx]) begin
                total++;
                assert (k - prev[idx] === 58 * 27) else begin
                    bad++;
                    $error("FAIL vbs_period%0d observed=%0d expected=%0d", idx, k - prev[idx], 58 * 27);
                end
                total++;
                assert (cvs[idx] === 2 * 58) else begin
                    bad++;
                    $error("FAIL vs_low%0d observed=%0d expected=%0d", idx, cvs[idx], 2 * 58);
                end
                total++;
                assert (cvb[idx] === 7 * 58) else begin
                    bad++;
                    $error("FAIL vb_high%0d observed=%0d expected=%0d", idx, cvb[idx], 7 * 58);
                end
            end
            prev[idx] = k; pv[idx] = 1'b1; cvs[idx] = 0; cvb[idx] = 0;
        end
        if (!vsv) cvs[idx]++;
        if (vbv) cvb[idx]++;
    endtask

    // Advance n clocks, checking every instance at each falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            int m;
            m = mode;
            @(posedge clk);
            if (!reset_n) k = 0;
            else k++;
            @(negedge clk);
            chk("big", obs0, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0, 1'b0, m);
            chk("s1", obs1, 40, 4, 8, 6, 20, 2, 2, 3, 1, 1'b0, 1'b0, m);
            chk("s3", obs3, 40, 4, 8, 6, 20, 2, 2, 3, 3, 1'b1, 1'b0, m);
            if (k == 0) first_de_k = -1;
            else if (u0_de && first_de_k < 0) first_de_k = k;
            if (win) begin
                if (!u0_hs) cnt_hs++;
                if (u0_de) cnt_de++;
            end
            frame_chk(0, u1_vbs, u1_vs, u1_vb);
            frame_chk(1, u3_vbs, u3_vs, u3_vb);
            if (!u0_de && u0_r === 8'hAA) aa_bad++;
            if (!u1_de && u1_r === 8'hAA) aa_bad++;
            if (!u3_de && u3_r === 8'hAA) aa_bad++;
        end
    endtask

    initial begin
        total = 0; bad = 0; k = 0; win = 1'b0; cnt_hs = 0; cnt_de = 0; aa_bad = 0;
        first_de_k = -1; key = 32'h0; pv[0] = 1'b0; pv[1] = 1'b0;

        // Reset held with the framebuffer driving all ones.
        mode = 0;
        reset_n = 1'b0;
        step(5);

        // Release; first two lines of the full-size instance.
        mode = 1;
        reset_n = 1'b1;
        step(2);
        win = 1'b1;
        step(1600);
        win = 1'b0;
        total++;
        assert (first_de_k === 3) else begin
            bad++;
            $error("FAIL first_de observed=%0d expected=%0d", first_de_k, 3);
        end
        total++;
        assert (cnt_hs === 192) else begin
            bad++;
            $error("FAIL hs_low_2lines observed=%0d expected=%0d", cnt_hs, 192);
        end
        total++;
        assert (cnt_de === 1280) else begin
            bad++;
            $error("FAIL de_2lines observed=%0d expected=%0d", cnt_de, 1280);
        end

        // Several reduced frames with address data, then hashed random data.
        step(2 * 1566 + 100);
        mode = 3;
        key = $urandom | 32'h1;
        step(1566 + 50);

        // Constant 8'hAA: must never reach r/g/b while blanked.
        mode = 2;
        step(1566);

        // One-cycle reset at line 10, pixel 30 of the reduced raster.
        for (int i = 0; i < 1566 && (k % 1566) != 10 * 58 + 30; i++) step(1);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(1600);

        // One-cycle reset at a random raster position, then address data again.
        target = int'($urandom_range(0, 1565));
        for (int i = 0; i < 1566 && (k % 1566) != target; i++) step(1);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        mode = 1;
        step(2 * 1566 + 20);

        total++;
        assert (aa_bad === 0) else begin
            bad++;
            $error("FAIL aa_in_blank observed=%0d expected=%0d", aa_bad, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
